// File: rtl/truth_table_sequencer_if.sv
// Stimulus/capture bundle between the truth-table sequencer and its surroundings.
// The master side (the sequencer) drives the vector and status, and reads the
// start request and the response of the gate under test.
interface truth_table_sequencer_if #(
  parameter int N_INPUTS = 2
);
  logic                     start;
  logic                     dut_out;
  logic [N_INPUTS-1:0]      vec;
  logic                     busy;
  logic                     done;
  logic [2**N_INPUTS-1:0]   truth_table;

  modport master (
    input  start,
    input  dut_out,
    output vec,
    output busy,
    output done,
    output truth_table
  );

  modport slave (
    output start,
    output dut_out,
    input  vec,
    input  busy,
    input  done,
    input  truth_table
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Clocked sweep of every input combination of a small gate under test.
// Each vector is held for HOLD_CYCLES cycles and the gate response is captured
// on the last edge of the hold window into bit <vector> of the truth table.
// The result register is named truth_table because "table" is a reserved word.
module truth_table_sequencer #(
  parameter int N_INPUTS    = 2,
  parameter int HOLD_CYCLES = 10
) (
  input logic                     clk,
  input logic                     reset,
  truth_table_sequencer_if.master bus
);

  localparam int NUM_VECS = 2 ** N_INPUTS;
  localparam int CNT_W    = $clog2(HOLD_CYCLES);

  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(NUM_VECS - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [N_INPUTS-1:0]   vec_q;
  logic [NUM_VECS-1:0]   tbl_q;

  logic                  sweep_start;
  logic                  window_end;
  logic                  last_vec;

  // A request only counts in IDLE; the window ends when the hold counter tops out.
  assign sweep_start = (state_q == IDLE) && bus.start;
  assign window_end  = (state_q == APPLY) && (cnt_q == LAST_CNT);
  assign last_vec    = (vec_q == LAST_VEC);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE always lasts one cycle, then falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (window_end && last_vec) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold counter: runs only in APPLY and restarts at every window boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (sweep_start) begin
      cnt_q <= '0;
    end else if (state_q == APPLY) begin
      if (cnt_q == LAST_CNT) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // Vector index: steps once per window and parks at zero after the final vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_q <= '0;
    end else if (sweep_start) begin
      vec_q <= '0;
    end else if (window_end) begin
      if (last_vec) begin
        vec_q <= '0;
      end else begin
        vec_q <= vec_q + N_INPUTS'(1);
      end
    end
  end

  // Result capture: cleared when a sweep starts, one bit written per window end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_q <= '0;
    end else if (sweep_start) begin
      tbl_q <= '0;
    end else if (window_end) begin
      tbl_q[vec_q] <= bus.dut_out;
    end
  end

  // Outputs decoded from state; the vector is only presented while applying.
  always_comb begin
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.vec         = '0;
    bus.truth_table = tbl_q;
    case (state_q)
      APPLY: begin
        bus.busy = 1'b1;
        bus.vec  = vec_q;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Synchronous stimulus and capture stage that sits directly upstream of a small combinational gate module under test.
- On a start request, drives every input combination in binary order and holds each for a programmable number of cycles.
- Samples the gate's output at the end of each hold window and packs the results into a truth-table register.
- Replaces hand-written delay-stepped stimulus with a clocked, self-timed sweep.

Parameters:
- N_INPUTS, 2, number of gate inputs driven; the sweep covers 2**N_INPUTS vectors.
- HOLD_CYCLES, 10, clock cycles each vector is held; legal range is 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  sweep request, sampled on the rising edge; honoured only in IDLE.
- dut_out  input  1  output of the gate under test.
- vec  output  N_INPUTS  current input vector to the gate; MSB drives gate input a, LSB drives gate input b.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table  output  2**N_INPUTS  captured responses; bit k holds dut_out for vector k.

Behaviour:
- Reset (async, active-high): all outputs and internal state take their reset values immediately, without waiting for clk.
  - state=IDLE, vec=0, busy=0, done=0, table=0, hold counter=0.
- Hold counter width is clog2(HOLD_CYCLES). Vector index width is N_INPUTS and it never wraps during a sweep.
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - vec=0, busy=0, done=0; table keeps the last sweep result.
  - start=1 at edge E0 moves to APPLY, clears table to 0, sets vec=0 and counter=0.
- APPLY:
  - busy=1; vec is held stable; counter increments on each edge.
  - At the edge where counter==HOLD_CYCLES-1:
    - table[vec] <= dut_out, where dut_out is the value present in the last cycle of the hold window.
    - counter <= 0.
    - If vec==2**N_INPUTS-1, go to DONE; otherwise vec <= vec+1.
  - Each vector is therefore held for exactly HOLD_CYCLES cycles. Vector k is applied from edge E0+k*HOLD_CYCLES.
- DONE:
  - Entered at edge E0+(2**N_INPUTS)*HOLD_CYCLES.
  - done=1 and busy=0 for exactly one cycle; vec returns to 0.
  - Unconditionally moves to IDLE on the next edge, where done drops to 0.
- start handling:
  - start is ignored in APPLY and DONE; it is not queued.
  - start held high continuously re-triggers a new sweep from IDLE. The result is one idle cycle between sweeps, i.e. DONE, IDLE, APPLY.
- Reset asserted mid-sweep:
  - The sweep is aborted and table is cleared.
  - No done pulse is emitted.
  - After reset releases, the block waits in IDLE for start.
- dut_out is sampled only at the hold-window end edges; changes at any other time have no effect.
- table changes only on capture edges and on sweep start; it is stable in IDLE, so software reads it after done.

Test Plan:
1. AND gate model, HOLD_CYCLES=10, pulse start:
   - vec sequence is 00, 01, 10, 11, each held exactly 10 cycles.
   - done pulses 40 cycles after the start edge and lasts 1 cycle.
   - table=4'b1000; busy high for exactly 40 cycles.
2. XOR model, then OR model, back-to-back sweeps:
   - First sweep: table=4'b0110.
   - Second sweep: table is cleared at its start, and ends at 4'b1110.
3. Pulse start again 5 cycles into a sweep:
   - Ignored; the sweep timing is unchanged.
   - Exactly one done pulse appears, at cycle 40.
4. Assert reset asynchronously (between clock edges) while vec=10:
   - vec, busy, done and table go to 0 immediately; no done pulse.
   - A fresh start after reset release gives the correct full table.
5. HOLD_CYCLES=2, N_INPUTS=3, NAND model:
   - 8 vectors, 2 cycles each; done at cycle 16.
   - table=8'b01111111.
6. dut_out glitched low, except in the final cycle of each window, with a constant-1 model:
   - table=all ones, confirming the end-of-window sampling point.
